uart_rx_deser: RTL
==================

// Module: uart_rx_deser
// PURPOSE
// UART receive deserialiser downstream of the GPIO block: consumes the registered uart_rx pad
// signal and drives uart_rts back into the GPIO mux. Oversamples 16x, majority-votes each bit,
// frames 8N1 bytes and buffers them in a small FIFO presented as a valid/ready stream.
// PARAMETERS
// W_DIV       16  width of clkdiv; system clocks per oversample tick = clkdiv + 1
// FIFO_DEPTH  4   RX FIFO entries, power of 2, >= 2
// PORTS
// clk          in   1                        system clock
// rst          in   1                        synchronous reset, active-high
// en           in   1                        receiver enable
// clkdiv       in   W_DIV                    oversample divider (sampled on tick reload)
// rxd          in   1                        serial in from GPIO (idle high)
// rts          out  1                        active-low flow control to GPIO uart_rts; 0 = send
// rx_data      out  8                        FIFO head byte
// rx_valid     out  1                        FIFO non-empty
// rx_ready     in   1                        consumer pop; pop = rx_valid & rx_ready
// level        out  $clog2(FIFO_DEPTH)+1     FIFO occupancy
// busy         out  1                        FSM not in IDLE
// framing_err  out  1                        1-cycle pulse: stop bit sampled 0
// overrun_err  out  1                        1-cycle pulse: byte dropped, FIFO full
// BEHAVIOUR
// - Reset: rts=1, rx_data=0, rx_valid=0, level=0, busy=0, both error pulses 0; sync flops=1.
// - rxd through 2-flop synchroniser (reset 1); FSM sees sync output only.
// - Tick counter: down-counts from clkdiv, tick on 0 then reloads; clkdiv=0 -> tick every clk.
//   Held at reload and FSM forced to IDLE while en=0 (partial byte discarded, FIFO kept).
// - Oversample counter os[3:0] counts ticks within a bit; samples taken at os=7,8,9, bit = majority.
// - FSM: IDLE, START, DATA, STOP, WAIT_IDLE.
//   IDLE: sync rxd==0 -> START, os=0, tick counter reloaded same cycle.
//   START: at os=15 tick: majority 0 -> DATA (bit 0); majority 1 -> IDLE (glitch, no error).
//   DATA: shift in LSB first; after 8th bit's os=15 tick -> STOP.
//   STOP: at os=9 tick decide: majority 1 -> push byte, IDLE; 0 -> framing_err, discard, WAIT_IDLE.
//   WAIT_IDLE: stay until sync rxd==1 for one tick, then IDLE (break condition absorbed).
// - Return to IDLE mid-stop-bit gives half-bit margin for sender clock up to ~+/-3%.
// - Push: byte written on the stop-decision cycle; rx_valid visible next cycle.
// - Full and push: overrun_err pulse, byte dropped, unless pop same cycle -> push accepted, level same.
// - Empty and pop: impossible (pop gated by rx_valid). Push+pop when non-full: level unchanged.
// - rx_data = head entry, combinational from storage; storage reset to 0.
// - rts registered: rts <= !(en && level_next < FIFO_DEPTH-1) (one slot margin for in-flight byte).
// - rst mid-frame: FSM IDLE, FIFO emptied, all outputs to reset values next cycle.
// STRUCTURE
// - Shared package uart_pkg: FSM state encodings, OS_SAMPLE_LO/MID/HI (7/8/9), OS_LAST (15).
// - Sub-module sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH): push/pop/full/empty/level, same-cycle
//   push+pop when full permitted. Tick gen, synchroniser, FSM, shift register stay in this module.
// TESTING
// - clkdiv=0, send 0xA5 8N1 at 16 clk/bit -> rx_data=0xA5, rx_valid=1 one clk after stop os=9; no errors.
// - clkdiv=3, rxd low for 3 ticks then high -> no push, busy 1 then 0, no error pulses.
// - Send 0x3C with stop=0, hold low 40 ticks, then 0x55 -> framing_err once, level 0, then 0x55 received.
// - FIFO_DEPTH=4, rx_ready=0, bytes 0x01..0x05 -> rts=1 once level=3, overrun on 5th, pops give 01..04.
// - FIFO full, rx_ready=1 on push cycle -> no overrun, level stays 4, new byte at tail.
// - en=0 or rst during DATA -> FSM IDLE, no push; rst also clears level to 0 and sets rts=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encodings, oversample
// sample points and a 2-of-3 majority helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  // Mid-bit sample points within a 16-tick bit, and the last tick of a bit.
  localparam logic [3:0] OS_SAMPLE_LO  = 4'd7;
  localparam logic [3:0] OS_SAMPLE_MID = 4'd8;
  localparam logic [3:0] OS_SAMPLE_HI  = 4'd9;
  localparam logic [3:0] OS_LAST       = 4'd15;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO. A push while full is accepted when a pop happens
// in the same cycle, so a full FIFO can stream without dropping.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level,
  output logic [LW-1:0]    level_next
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic                        do_push;
  logic                        do_pop;

  assign full       = (level == LW'(DEPTH));
  assign empty      = (level == '0);
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign level_next = level + LW'(do_push) - LW'(do_pop);
  assign rdata      = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level_next;
    end
  end

endmodule

// File: rtl/uart_rx_deser.sv
// UART 8N1 receiver: 16x oversampling with 3-sample majority vote per bit,
// received bytes buffered in a FIFO exposed as a valid/ready stream, with
// active-low RTS flow control back to the pad mux.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter  int W_DIV      = 16,
  parameter  int FIFO_DEPTH = 4,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [W_DIV-1:0] clkdiv,
  input  logic             rxd,
  output logic             rts,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [LW-1:0]    level,
  output logic             busy,
  output logic             framing_err,
  output logic             overrun_err
);

  rx_state_e        state, state_nx;
  logic [1:0]       sync_q;
  logic             rxs;
  logic [W_DIV-1:0] div_cnt;
  logic             tick;
  logic [3:0]       os;
  logic [2:0]       samp;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             maj_win;
  logic             maj_stop;
  logic             push_req;
  logic             frame_det;
  logic             pop;
  logic             full;
  logic             empty;
  logic [LW-1:0]    level_next;

  assign rxs      = sync_q[1];
  assign tick     = en && (div_cnt == '0);
  // Full-window vote for start/data; the stop vote uses the live third sample
  // so the decision lands on the os=9 tick itself.
  assign maj_win  = maj3(samp[0], samp[1], samp[2]);
  assign maj_stop = maj3(samp[0], samp[1], rxs);
  assign pop      = rx_valid && rx_ready;
  assign rx_valid = !empty;

  // Two-flop synchroniser on the pad input, idle-high reset.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rxd};
  end

  // Tick divider, oversample counter, vote samples and data shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      os      <= '0;
      samp    <= 3'b111;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (!en) begin
      div_cnt <= clkdiv;
      os      <= '0;
    end else if (state == ST_IDLE && !rxs) begin
      // Align bit timing to the detected start edge.
      div_cnt <= clkdiv;
      os      <= '0;
    end else if (tick) begin
      div_cnt <= clkdiv;
      os      <= os + 4'd1;
      if (os == OS_SAMPLE_LO)  samp[0] <= rxs;
      if (os == OS_SAMPLE_MID) samp[1] <= rxs;
      if (os == OS_SAMPLE_HI)  samp[2] <= rxs;
      if (state == ST_START && os == OS_LAST) bit_cnt <= '0;
      if (state == ST_DATA && os == OS_LAST) begin
        shreg   <= {maj_win, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end else begin
      div_cnt <= div_cnt - W_DIV'(1);
    end
  end

  // FSM state register; disabling the receiver abandons any partial byte.
  always_ff @(posedge clk) begin
    if (rst || !en) state <= ST_IDLE;
    else            state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      if (!rxs) state_nx = ST_START;
      ST_START:     if (tick && os == OS_LAST) state_nx = maj_win ? ST_IDLE : ST_DATA;
      ST_DATA:      if (tick && os == OS_LAST && bit_cnt == 3'd7) state_nx = ST_STOP;
      ST_STOP:      if (tick && os == OS_SAMPLE_HI) state_nx = maj_stop ? ST_IDLE : ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (tick && rxs) state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  // FSM outputs: stop-bit decision produces either a push or a framing error.
  always_comb begin
    push_req  = 1'b0;
    frame_det = 1'b0;
    busy      = (state != ST_IDLE);
    if (state == ST_STOP && tick && os == OS_SAMPLE_HI) begin
      if (maj_stop) push_req  = 1'b1;
      else          frame_det = 1'b1;
    end
  end

  // Error pulses and RTS; RTS keeps one slot free for a byte already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
      rts         <= 1'b1;
    end else begin
      framing_err <= frame_det;
      overrun_err <= push_req && full && !pop;
      rts         <= !(en && (level_next < LW'(FIFO_DEPTH - 1)));
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_req),
    .wdata      (shreg),
    .pop        (pop),
    .rdata      (rx_data),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .level_next (level_next)
  );

endmodule
